// File: rtl/fetch_align_buffer.sv
// Two-entry instruction block buffer between fetch and the ilowX port.
// Extracts 16/32-bit instructions at halfword PCs, including block straddles.
module fetch_align_buffer #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  input  logic [XLEN-1:0]     pc_i,
  output logic                inst_valid_o,
  output logic [31:0]         inst_o,
  output logic                is_comp_o,
  output logic                lowx_req_valid_o,
  input  logic                lowx_req_ready_i,
  output logic [XLEN-1:0]     lowx_req_addr_o,
  input  logic                lowx_res_valid_i,
  input  logic [BLK_SIZE-1:0] lowx_res_blk_i
);

  localparam int NHW  = BLK_SIZE / 16;
  localparam int HWW  = $clog2(NHW);
  localparam int OFFW = HWW + 1;
  localparam int TAGW = XLEN - OFFW;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          valid_q, valid_d;
  logic                lru_q, lru_d;
  logic                drop_q, drop_d;
  logic [TAGW-1:0]     miss_tag_q, miss_tag_d;
  logic                victim_q, victim_d;
  logic [TAGW-1:0]     tag_q [2];
  logic [BLK_SIZE-1:0] blk_q [2];
  logic                fill_we;

  function automatic logic [15:0] get_hw(
    input logic [BLK_SIZE-1:0] b,
    input logic [HWW-1:0]      i
  );
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < NHW; k++) begin
      if (i == HWW'(k)) r = b[16*k +: 16];
    end
    return r;
  endfunction

  logic [TAGW-1:0]     lo_tag, hi_tag;
  logic [HWW-1:0]      lo_off, up_off;
  logic [1:0]          lo_hit_v, hi_hit_v;
  logic                lo_sel, hi_sel;
  logic                lo_ok, hi_ok, all_hit;
  logic [15:0]         lo_hw, up_hw;
  logic                is_comp, straddle;
  logic                idle, hit, miss;
  logic                unused_pc0;

  assign unused_pc0 = pc_i[0];

  assign lo_tag = pc_i[XLEN-1:OFFW];
  assign hi_tag = lo_tag + 1'b1;
  assign lo_off = pc_i[OFFW-1:1];
  assign up_off = lo_off + 1'b1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lo_hit_v[i] = valid_q[i] && (tag_q[i] == lo_tag);
      hi_hit_v[i] = valid_q[i] && (tag_q[i] == hi_tag);
    end
  end

  assign lo_sel   = !lo_hit_v[0];
  assign hi_sel   = !hi_hit_v[0];
  assign lo_ok    = |lo_hit_v;
  assign lo_hw    = get_hw(blk_q[lo_sel], lo_off);
  assign is_comp  = lo_hw[1:0] != 2'b11;
  assign straddle = !is_comp && (lo_off == '1);
  assign up_hw    = straddle ? get_hw(blk_q[hi_sel], '0)
                             : get_hw(blk_q[lo_sel], up_off);
  assign hi_ok    = straddle ? |hi_hit_v : 1'b1;
  assign all_hit  = lo_ok && hi_ok;

  assign idle = state_q == IDLE;
  assign hit  = req_valid_i && idle && all_hit && !flush_i;
  assign miss = req_valid_i && idle && !all_hit && !flush_i;

  assign inst_valid_o = hit;
  assign is_comp_o    = hit && is_comp;
  assign inst_o       = !hit   ? 32'h0 :
                        is_comp ? {16'h0, lo_hw} : {up_hw, lo_hw};

  always_comb begin
    state_d          = state_q;
    valid_d          = valid_q;
    lru_d            = lru_q;
    drop_d           = drop_q;
    miss_tag_d       = miss_tag_q;
    victim_d         = victim_q;
    fill_we          = 1'b0;
    lowx_req_valid_o = 1'b0;
    lowx_req_addr_o  = '0;

    if (hit) lru_d = ~lo_sel;

    unique case (state_q)
      IDLE: begin
        if (miss) begin
          // Lower miss first; never evict the block the other half lives in.
          if (lo_ok) begin
            miss_tag_d = hi_tag;
            victim_d   = ~lo_sel;
          end else begin
            miss_tag_d = lo_tag;
            victim_d   = ((lo_off == '1) && |hi_hit_v) ? ~hi_sel : lru_q;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        lowx_req_valid_o = 1'b1;
        lowx_req_addr_o  = {miss_tag_q, OFFW'(0)};
        if (flush_i) drop_d = 1'b1;
        if (lowx_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (lowx_res_valid_i) begin
          if (!(drop_q || flush_i)) begin
            fill_we           = 1'b1;
            valid_d[victim_q] = 1'b1;
            lru_d             = ~victim_q;
          end
          drop_d  = 1'b0;
          state_d = IDLE;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      lru_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lru_q   <= lru_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    miss_tag_q <= miss_tag_d;
    victim_q   <= victim_d;
    if (fill_we) begin
      tag_q[victim_q] <= miss_tag_q;
      blk_q[victim_q] <= lowx_res_blk_i;
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer: misses, hits, straddles,
// flush during a fill and reset with a request outstanding.
module tb_fetch_align_buffer;

  logic         clk = 1'b0;
  logic         rst, flush, req, ready, res;
  logic [31:0]  pc;
  logic [127:0] blk;
  logic         inst_valid, is_comp, lreq_valid;
  logic [31:0]  inst, lreq_addr;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;
  int nreq   = 0;

  localparam logic [127:0] B100 = {16'h0513, 16'h0000, 16'h0000, 16'h0000,
                                   16'h0000, 16'h4501, 16'h0013, 16'h0513};
  localparam logic [127:0] B110 = {16'h4501, 96'h0, 16'h0013};
  localparam logic [127:0] B200 = {96'h0, 16'hABCD, 16'h0013};
  localparam logic [127:0] B300 = {112'h0, 16'h0001};

  always #5 clk = ~clk;

  fetch_align_buffer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .req_valid_i      (req),
    .pc_i             (pc),
    .inst_valid_o     (inst_valid),
    .inst_o           (inst),
    .is_comp_o        (is_comp),
    .lowx_req_valid_o (lreq_valid),
    .lowx_req_ready_i (ready),
    .lowx_req_addr_o  (lreq_addr),
    .lowx_res_valid_i (res),
    .lowx_res_blk_i   (blk)
  );

  always @(posedge clk) begin
    if (!rst && lreq_valid && ready) nreq <= nreq + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1; flush = 0; req = 0; ready = 0; res = 0;
    pc = 0; blk = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_is_comp", 32'(is_comp), 0);
    chk("rst_req_valid", 32'(lreq_valid), 0);

    // cold miss at 0x100
    @(negedge clk); rst = 0; req = 1; pc = 32'h100; ready = 1; #1;
    chk("cold_no_hit", 32'(inst_valid), 0);
    chk("cold_idle_noreq", 32'(lreq_valid), 0);
    @(negedge clk); #1;
    chk("cold_req_valid", 32'(lreq_valid), 1);
    chk("cold_req_addr", lreq_addr, 32'h100);
    @(negedge clk); res = 1; blk = B100; #1;
    chk("cold_wait_no_hit", 32'(inst_valid), 0);
    @(negedge clk); res = 0; #1;
    chk("cold_hit_valid", 32'(inst_valid), 1);
    chk("cold_hit_inst", inst, 32'h00130513);
    chk("cold_hit_comp", 32'(is_comp), 0);
    chk("cold_nreq", nreq, 1);

    // compressed hit, same block
    pc = 32'h104; #1;
    chk("comp_valid", 32'(inst_valid), 1);
    chk("comp_inst", inst, 32'h00004501);
    chk("comp_is_comp", 32'(is_comp), 1);
    chk("comp_noreq", 32'(lreq_valid), 0);

    // straddle 0x10E -> needs 0x110
    @(negedge clk); pc = 32'h10E; #1;
    chk("strad_miss", 32'(inst_valid), 0);
    @(negedge clk); #1;
    chk("strad_req_valid", 32'(lreq_valid), 1);
    chk("strad_req_addr", lreq_addr, 32'h110);
    @(negedge clk); res = 1; blk = B110; #1;
    @(negedge clk); res = 0; #1;
    chk("strad_valid", 32'(inst_valid), 1);
    chk("strad_inst", inst, 32'h00130513);
    chk("strad_comp", 32'(is_comp), 0);
    chk("strad_nreq", nreq, 2);
    pc = 32'h100; #1;
    chk("strad_keep_valid", 32'(inst_valid), 1);
    chk("strad_keep_inst", inst, 32'h00130513);

    // compressed at end of block: no request for 0x120
    pc = 32'h11E; #1;
    chk("cend_valid", 32'(inst_valid), 1);
    chk("cend_inst", inst, 32'h00004501);
    chk("cend_comp", 32'(is_comp), 1);
    @(negedge clk); #1;
    chk("cend_noreq", 32'(lreq_valid), 0);
    chk("cend_nreq", nreq, 2);

    // flush while waiting for 0x200
    pc = 32'h200; #1;
    chk("fw_miss", 32'(inst_valid), 0);
    @(negedge clk); #1;
    chk("fw_req_addr", lreq_addr, 32'h200);
    @(negedge clk); flush = 1; #1;
    chk("fw_flush_no_hit", 32'(inst_valid), 0);
    @(negedge clk); flush = 0; res = 1; blk = B200; #1;
    @(negedge clk); res = 0; #1;
    chk("fw_discard", 32'(inst_valid), 0);
    chk("fw_idle_noreq", 32'(lreq_valid), 0);
    @(negedge clk); #1;
    chk("fw_fresh_req", 32'(lreq_valid), 1);
    chk("fw_fresh_addr", lreq_addr, 32'h200);
    @(negedge clk); res = 1; blk = B200; #1;
    @(negedge clk); res = 0; #1;
    chk("fw_hit_valid", 32'(inst_valid), 1);
    chk("fw_hit_inst", inst, 32'hABCD0013);
    chk("fw_nreq", nreq, 4);
    pc = 32'h100; #1;
    chk("fw_0x100_gone", 32'(inst_valid), 0);
    pc = 32'h11E; #1;
    chk("fw_0x110_gone", 32'(inst_valid), 0);

    // flush in IDLE masks an otherwise valid hit
    pc = 32'h200; flush = 1; #1;
    chk("fi_valid", 32'(inst_valid), 0);
    chk("fi_inst", inst, 0);
    @(negedge clk); flush = 0; ready = 0; #1;
    chk("fi_cleared", 32'(inst_valid), 0);
    pc = 32'h300; #1;

    // reset mid-REQ, then an orphan response
    @(negedge clk); #1;
    chk("rr_req_valid", 32'(lreq_valid), 1);
    chk("rr_req_addr", lreq_addr, 32'h300);
    @(negedge clk); #1;
    chk("rr_req_held", 32'(lreq_valid), 1);
    chk("rr_addr_held", lreq_addr, 32'h300);
    rst = 1;
    @(negedge clk); rst = 0; req = 0; res = 1; blk = B300; #1;
    chk("rr_req_dropped", 32'(lreq_valid), 0);
    @(negedge clk); res = 0; req = 1; pc = 32'h300; #1;
    chk("rr_orphan_ignored", 32'(inst_valid), 0);
    @(negedge clk); req = 0; #1;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Sits between the fetch stage and the instruction-side lower memory port (ilowX request/response).
- Holds two 128-bit instruction blocks and extracts the 16- or 32-bit instruction at a halfword-aligned PC.
- This includes 32-bit instructions that straddle a block boundary.
- Produces `inst_o` and `is_comp_o`, which fill the `inst` and `is_comp` fields of the fetch→decode pipe register.

Parameters:
- XLEN, 32, address/instruction width
- BLK_SIZE, 128, block width in bits (8 halfwords)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  invalidate both entries (fence.i / redirect-with-invalidate)
- req_valid_i  in  1  fetch requests instruction at pc_i
- pc_i  in  XLEN  fetch PC; pc_i[0] is always 0
- inst_valid_o  out  1  inst_o/is_comp_o valid for pc_i this cycle
- inst_o  out  32  instruction; compressed instructions are zero-extended to {16'h0, hw}
- is_comp_o  out  1  1 when the low halfword has [1:0] != 2'b11
- lowx_req_valid_o  out  1  block request valid
- lowx_req_ready_i  in  1  lower level accepts the request
- lowx_req_addr_o  out  XLEN  block address {tag, 4'b0}
- lowx_res_valid_i  in  1  response block valid (single-cycle pulse)
- lowx_res_blk_i  in  BLK_SIZE  response block; halfword k = blk[16k+15:16k]

Behaviour:
- Storage: 2 entries {valid, tag[27:0], blk[127:0]} plus a 1-bit LRU pointer naming the victim entry.
- Lookup (combinational):
  - lo_tag = pc_i[31:4], lo_off = pc_i[3:1].
  - Lower halfword hits if either valid entry has tag == lo_tag.
  - is_comp_o is computed from the lower halfword.
  - If not compressed and lo_off == 7, the upper halfword is halfword 0 of the entry with tag == lo_tag+1 (28-bit wrap: 0xFFFFFFF+1 = 0).
  - Otherwise the upper halfword is halfword lo_off+1 of the same entry.
- inst_valid_o = req_valid_i & state==IDLE & all needed halfwords hit & !flush_i. Hits have zero-cycle latency.
- A hit on an entry sets LRU to the other entry.
- States:
  - IDLE: on req_valid_i with a miss, latch miss_tag and go to REQ. The lower-halfword miss is serviced first; the upper miss is serviced on re-evaluation.
  - REQ: lowx_req_valid_o = 1 and lowx_req_addr_o = {miss_tag, 4'b0}, both held stable until lowx_req_ready_i. On the ready cycle go to WAIT.
  - WAIT: on lowx_res_valid_i, write the block into the LRU entry (valid=1, tag=miss_tag), flip LRU, go to IDLE.
  - If a straddling instruction needs both blocks, the victim is never the entry holding the other needed tag; the fill forces the other entry.
- Miss tag is captured at IDLE→REQ; pc_i changes during REQ/WAIT do not alter the outstanding request.
- flush_i:
  - Clears both valid bits next cycle.
  - In REQ: the request completes its handshake (addr not withdrawn once valid).
  - In REQ or WAIT: sets a drop flag, and the response is discarded (no entry write). FSM → IDLE after the response.
  - flush_i in IDLE: inst_valid_o = 0 that cycle.
- Reset:
  - Valids = 0, LRU = 0, state IDLE, drop = 0.
  - lowx_req_valid_o = 0, inst_valid_o = 0, inst_o = 0, is_comp_o = 0 (outputs driven 0 when not valid).
  - Reset mid-transaction abandons the request. The lower level must tolerate an orphan response: any lowx_res_valid_i in IDLE is ignored.
- Only one request is outstanding at a time.
- lowx_res_valid_i in REQ is ignored.

Test Plan:
- Cold miss: reset, pc_i=0x100, mem[0x100..0x10F] = 0x...00130513 → one request addr=0x100; 1 cycle after the response, inst_valid_o=1, inst_o=0x00130513, is_comp_o=0.
- Compressed hit: same block resident, pc_i=0x104 holding 0x4501 → same-cycle inst_valid_o=1, inst_o=0x00004501, is_comp_o=1, no request.
- Straddle: pc_i=0x10E, low hw=0x0513, block 0x110 hw0=0x0013 → exactly one extra request addr=0x110, then inst_o=0x00130513; the entry for 0x100 is retained (not evicted).
- Straddle of compressed: pc_i=0x11E with hw[1:0]=2'b01 → hit with no request for 0x120.
- Flush in WAIT: miss at 0x200, assert flush_i while waiting → response discarded, both valids 0, next req_valid_i at 0x200 issues a fresh request.
- Reset mid-REQ with lowx_req_ready_i=0 → next cycle lowx_req_valid_o=0, state IDLE, an orphan response pulse causes no entry write.
